// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state type and opcode helper for the
// sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_DIV = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Bit-serial unsigned shift-add multiplier / restoring divider sharing one
// accumulator/shift-register pair; one bit per step, WIDTH steps.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi, lo, opb;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH:0]   sum, shifted, trial;

    // MUL: hi:lo shifts right with the partial sum; DIV: hi is the partial
    // remainder and lo shifts the dividend out while quotient bits shift in.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted - {1'b0, opb};
        if (is_div) begin
            hi_n = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            opb <= '0;
            cnt <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a_mag;
            opb <= b_mag;
            cnt <= '0;
        end else if (step) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
        end
    end

    assign res_hi = hi;
    assign res_lo = lo;
    assign last   = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus multi-cycle signed
// MUL/DIV driven through the alu_muldiv datapath.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [3:0]       iCtrl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oC_hi,
    output logic [WIDTH-1:0] oC_lo,
    output logic             oZero,
    output logic             oNeg,
    output logic             oOvf,
    output logic             oDivZero
);
    import alu_pkg::*;

    state_t           state;
    logic             op_div_r, res_neg_r, rem_neg_r, dz_r, ovf_r;
    logic [WIDTH-1:0] a_r;

    logic             b_zero, is_div_op, md_load, md_step, md_last;
    logic [WIDTH-1:0] a_mag, b_mag, md_hi, md_lo;
    logic [WIDTH-1:0] add_b, add_sum, s_lo;
    logic             add_ovf, s_ovf;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] f_hi, f_lo;
    logic [WIDTH-1:0] min_val;

    assign min_val   = {1'b1, {(WIDTH-1){1'b0}}};
    assign b_zero    = (iB == '0);
    assign is_div_op = (iCtrl == OP_DIV);
    assign a_mag     = iA[WIDTH-1] ? -iA : iA;
    assign b_mag     = iB[WIDTH-1] ? -iB : iB;
    assign md_load   = (state == IDLE) && iStart && is_muldiv(iCtrl) && !(is_div_op && b_zero);
    assign md_step   = (state == ITER);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (iClk),
        .rst    (iRst),
        .load   (md_load),
        .step   (md_step),
        .is_div (op_div_r),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .res_hi (md_hi),
        .res_lo (md_lo),
        .last   (md_last)
    );

    always_comb begin
        add_b   = (iCtrl == OP_SUB) ? ~iB : iB;
        add_sum = iA + add_b + WIDTH'(iCtrl == OP_SUB);
        add_ovf = (iA[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != iA[WIDTH-1]);
        s_ovf   = 1'b0;
        case (iCtrl)
            OP_ADD, OP_SUB: begin
                s_lo  = add_sum;
                s_ovf = add_ovf;
            end
            OP_OR:   s_lo = iA | iB;
            OP_XOR:  s_lo = iA ^ iB;
            OP_AND:  s_lo = iA & iB;
            OP_SLL:  s_lo = iA << iB[SHW-1:0];
            OP_SRL:  s_lo = iA >> iB[SHW-1:0];
            OP_SRA:  s_lo = WIDTH'($signed(iA) >>> iB[SHW-1:0]);
            default: s_lo = '0;
        endcase
    end

    // Sign correction of the magnitude results, applied in FIX.
    always_comb begin
        prod = {md_hi, md_lo};
        if (dz_r) begin
            f_hi = '1;
            f_lo = a_r;
        end else if (op_div_r) begin
            f_hi = res_neg_r ? -md_lo : md_lo;
            f_lo = rem_neg_r ? -md_hi : md_hi;
        end else begin
            {f_hi, f_lo} = res_neg_r ? -prod : prod;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oC_hi     <= '0;
            oC_lo     <= '0;
            oZero     <= 1'b0;
            oNeg      <= 1'b0;
            oOvf      <= 1'b0;
            oDivZero  <= 1'b0;
            op_div_r  <= 1'b0;
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            dz_r      <= 1'b0;
            ovf_r     <= 1'b0;
            a_r       <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        if (is_muldiv(iCtrl)) begin
                            op_div_r  <= is_div_op;
                            res_neg_r <= iA[WIDTH-1] ^ iB[WIDTH-1];
                            rem_neg_r <= iA[WIDTH-1];
                            dz_r      <= is_div_op && b_zero;
                            ovf_r     <= is_div_op && (iA == min_val) && (iB == '1);
                            a_r       <= iA;
                            oBusy     <= 1'b1;
                            state     <= (is_div_op && b_zero) ? FIX : ITER;
                        end else begin
                            oC_hi    <= '0;
                            oC_lo    <= s_lo;
                            oZero    <= (s_lo == '0);
                            oNeg     <= s_lo[WIDTH-1];
                            oOvf     <= s_ovf;
                            oDivZero <= 1'b0;
                            oDone    <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (md_last) state <= FIX;
                end
                FIX: begin
                    oC_hi    <= f_hi;
                    oC_lo    <= f_lo;
                    oZero    <= ({f_hi, f_lo} == '0);
                    oNeg     <= f_hi[WIDTH-1];
                    oOvf     <= ovf_r;
                    oDivZero <= dz_r;
                    oDone    <= 1'b1;
                    oBusy    <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized ops,
// checked against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 32;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         iStart = 1'b0;
    logic [3:0]   iCtrl = '0;
    logic [W-1:0] iA = '0;
    logic [W-1:0] iB = '0;
    logic         oBusy, oDone, oZero, oNeg, oOvf, oDivZero;
    logic [W-1:0] oC_hi, oC_lo;

    alu_seq #(.WIDTH(W)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iStart   (iStart),
        .iCtrl    (iCtrl),
        .iA       (iA),
        .iB       (iB),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oC_hi    (oC_hi),
        .oC_lo    (oC_lo),
        .oZero    (oZero),
        .oNeg     (oNeg),
        .oOvf     (oOvf),
        .oDivZero (oDivZero)
    );

    always #5 iClk = ~iClk;

    int unsigned cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi, lo;
        logic         z, n, o, d;
        int unsigned  done_at;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;

    localparam logic [W-1:0] MIN = 32'h8000_0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb_, r, q, rm;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.hi = '0; e.lo = '0; e.z = 0; e.n = 0; e.o = 0; e.d = 0; e.done_at = 0;
        case (op)
            4'd0, 4'd1: begin
                r = (op == 4'd0) ? sa + sb_ : sa - sb_;
                e.lo = r[W-1:0];
                e.o  = (r != longint'($signed(e.lo)));
                e.n  = e.lo[W-1];
            end
            4'd2: begin e.lo = a | b; e.n = e.lo[W-1]; end
            4'd3: begin e.lo = a ^ b; e.n = e.lo[W-1]; end
            4'd4: begin e.lo = a & b; e.n = e.lo[W-1]; end
            4'd5: begin
                p = sa * sb_;
                {e.hi, e.lo} = p;
                e.n = e.hi[W-1];
            end
            4'd6: begin
                if (b == '0) begin
                    e.hi = '1; e.lo = a; e.d = 1;
                end else begin
                    q  = sa / sb_;
                    rm = sa % sb_;
                    e.hi = q[W-1:0];
                    e.lo = rm[W-1:0];
                    e.o  = (q != longint'($signed(e.hi)));
                end
                e.n = e.hi[W-1];
            end
            4'd7: begin e.lo = a << b[4:0]; e.n = e.lo[W-1]; end
            4'd8: begin e.lo = a >> b[4:0]; e.n = e.lo[W-1]; end
            4'd9: begin e.lo = $unsigned($signed(a) >>> b[4:0]); e.n = e.lo[W-1]; end
            default: ;
        endcase
        e.z = ({e.hi, e.lo} == 64'd0);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return MIN;
            2: return '1;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request; returns just after the edge on which oDone rises,
    // so a following call starts in the oDone cycle.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject);
        exp_t        e;
        int unsigned lat;
        e   = model(op, a, b);
        lat = (op == 4'd5 || (op == 4'd6 && b != '0)) ? W + 1 : ((op == 4'd6) ? 1 : 0);
        e.done_at = cyc + 1 + lat;
        sb.push_back(e);
        iCtrl = op; iA = a; iB = b; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0; iA = $urandom; iB = $urandom; iCtrl = 4'($urandom);
        for (int k = 1; k <= int'(lat); k++) begin
            check("busy_during", 64'(oBusy), 64'd1);
            if (inject && k == 5) begin
                iStart = 1'b1; iCtrl = 4'd1;
            end
            @(posedge iClk); #1;
            iStart = 1'b0;
        end
        check("busy_after", 64'(oBusy), 64'd0);
    endtask

    always @(negedge iClk) begin
        if (!iRst) begin
            if (oDone) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(mon_e.done_at));
                    check("result", {oC_hi, oC_lo}, {mon_e.hi, mon_e.lo});
                    check("flags", 64'({oZero, oNeg, oOvf, oDivZero}),
                          64'({mon_e.z, mon_e.n, mon_e.o, mon_e.d}));
                    last = mon_e;
                end
            end else begin
                check("hold_result", {oC_hi, oC_lo}, {last.hi, last.lo});
                check("hold_flags", 64'({oZero, oNeg, oOvf, oDivZero}),
                      64'({last.z, last.n, last.o, last.d}));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        last.hi = '0; last.lo = '0;
        last.z = 0; last.n = 0; last.o = 0; last.d = 0; last.done_at = 0;

        repeat (3) @(posedge iClk);
        #1;
        check("reset_ctrl", 64'({oBusy, oDone}), 64'd0);
        check("reset_result", {oC_hi, oC_lo}, 64'd0);
        check("reset_flags", 64'({oZero, oNeg, oOvf, oDivZero}), 64'd0);
        iRst = 1'b0;

        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        issue(4'd5, 32'hFFFF_FFFD, 32'd7, 0);
        issue(4'd6, 32'hFFFF_FFF9, 32'd2, 0);
        issue(4'd6, 32'd7, 32'd0, 0);
        issue(4'd6, MIN, 32'hFFFF_FFFF, 0);
        issue(4'd5, MIN, MIN, 0);
        issue(4'd1, MIN, 32'd1, 0);
        issue(4'd1, 32'd5, 32'd5, 0);
        issue(4'd7, 32'd1, 32'd31, 0);
        issue(4'd9, MIN, 32'h0000_0024, 0);
        issue(4'd8, MIN, 32'd4, 0);
        issue(4'd12, 32'd5, 32'd5, 0);
        issue(4'd2, 32'hF0F0_0000, 32'h0000_0F0F, 0);
        issue(4'd3, 32'hFFFF_0000, 32'hFFFF_FFFF, 0);
        issue(4'd4, 32'hAAAA_AAAA, 32'h5555_5555, 0);
        issue(4'd6, 32'd0, 32'd5, 0);
        issue(4'd6, 32'd7, 32'hFFFF_FFFE, 0);

        // stray start during MUL, then SUB in the oDone cycle
        issue(4'd5, 32'd1234, 32'hFFFF_FF00, 1);
        issue(4'd1, 32'd10, 32'd3, 0);

        // reset in the middle of a DIV
        iCtrl = 4'd6; iA = 32'd100; iB = 32'd3; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (9) @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(posedge iClk); #1;
        check("abort_ctrl", 64'({oBusy, oDone}), 64'd0);
        check("abort_result", {oC_hi, oC_lo}, 64'd0);
        check("abort_flags", 64'({oZero, oNeg, oOvf, oDivZero}), 64'd0);
        last.hi = '0; last.lo = '0;
        last.z = 0; last.n = 0; last.o = 0; last.d = 0;
        iRst = 1'b0;
        issue(4'd0, 32'd2, 32'd2, 0);

        for (int i = 0; i < 200; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 11));
            if (op == 4'd11) op = 4'd15;
            issue(op, rnd_operand(), rnd_operand(), 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge iClk); #1;
            end
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge iClk);
        #1;
        check("drain", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
